// File: rtl/usb2_ep0in_tx.sv
// usb2_ep0in_tx: EP0 IN packet reader.
// Reads up to 64 bytes from the EP0 IN RAM, which has a two-clock read latency.
// The bytes pass through a small skid FIFO to a tx_valid/tx_ready byte stream.
// Optional feature: define USB2_EP0IN_ZLP_EN to turn start with len=0 into a
// one-cycle tx_zlp request followed by a done pulse. By default, such a start
// is ignored and tx_zlp is tied low.
module usb2_ep0in_tx #(
    parameter int SKID_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic [6:0] len,
    input  logic       abort,
    output logic [5:0] rd_adr,
    input  logic [7:0] rd_dat_r,
    output logic       tx_valid,
    output logic [7:0] tx_data,
    output logic       tx_last,
    input  logic       tx_ready,
    output logic       tx_zlp,
    output logic       busy,
    output logic       done
);

    localparam int PW = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
    localparam int CW = $clog2(SKID_DEPTH + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]    state_reg;
    logic [6:0]    n_reg;
    logic [6:0]    iss_cnt_reg;
    logic [6:0]    acc_cnt_reg;
    logic [5:0]    adr_reg;
    logic          vld1_reg;
    logic          vld2_reg;
    logic          zlp_reg;
    logic [7:0]    fifo_mem [SKID_DEPTH];
    logic [PW-1:0] wr_ptr_reg;
    logic [PW-1:0] rd_ptr_reg;
    logic [CW-1:0] cnt_reg;

    logic [6:0]    len_clamp;
    logic [CW:0]   occ;
    logic          in_pkt;
    logic          abort_hit;
    logic          issue;
    logic          push;
    logic          pop;
    logic          fifo_empty;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(SKID_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign len_clamp  = (len > 7'd64) ? 7'd64 : len;
    assign fifo_empty = (cnt_reg == '0);
    assign in_pkt     = (state_reg == S_FETCH) || (state_reg == S_FLUSH);
    assign abort_hit  = abort && in_pkt;

    // Count stored bytes plus reads still in the RAM pipeline.
    // Counting every in-flight read keeps the FIFO from overflowing, even if
    // the transmitter stalls.
    assign occ   = {1'b0, cnt_reg} + {{CW{1'b0}}, vld1_reg} + {{CW{1'b0}}, vld2_reg};
    assign issue = (state_reg == S_FETCH) && !abort && (occ < (CW+1)'(SKID_DEPTH));
    assign push  = vld2_reg;
    assign pop   = !fifo_empty && tx_ready && !abort_hit;

    // The address goes to the RAM in the cycle the read is issued.
    // Otherwise rd_adr holds its last value, because the RAM has no read enable.
    assign rd_adr   = issue ? iss_cnt_reg[5:0] : adr_reg;
    assign tx_valid = !fifo_empty;
    assign tx_data  = fifo_empty ? 8'h00 : fifo_mem[rd_ptr_reg];
    assign tx_last  = tx_valid && (acc_cnt_reg == n_reg - 7'd1);
    assign busy     = in_pkt || zlp_reg;
    assign done     = (state_reg == S_DONE);
`ifdef USB2_EP0IN_ZLP_EN
    assign tx_zlp   = zlp_reg;
`else
    assign tx_zlp   = 1'b0;
`endif

    // Packet sequencer: handles start and abort, issues addresses, and completes the packet.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg   <= S_IDLE;
            n_reg       <= '0;
            iss_cnt_reg <= '0;
            adr_reg     <= '0;
            zlp_reg     <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (zlp_reg) begin
                        zlp_reg   <= 1'b0;
                        state_reg <= S_DONE;
                    end else if (start) begin
                        if (len_clamp != 7'd0) begin
                            n_reg       <= len_clamp;
                            iss_cnt_reg <= '0;
                            state_reg   <= S_FETCH;
                        end
`ifdef USB2_EP0IN_ZLP_EN
                        else begin
                            zlp_reg <= 1'b1;
                        end
`endif
                    end
                end
                S_FETCH: begin
                    if (abort) begin
                        state_reg <= S_DONE;
                    end else if (issue) begin
                        iss_cnt_reg <= iss_cnt_reg + 7'd1;
                        adr_reg     <= iss_cnt_reg[5:0];
                        if (iss_cnt_reg == n_reg - 7'd1) begin
                            state_reg <= S_FLUSH;
                        end
                    end
                end
                S_FLUSH: begin
                    if (abort) begin
                        state_reg <= S_DONE;
                    end else if (pop && tx_last) begin
                        state_reg <= S_DONE;
                    end
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    // Accept counter. It is cleared when a new packet is accepted, and tx_last is derived from it.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            acc_cnt_reg <= '0;
        end else if (state_reg == S_IDLE && !zlp_reg && start && len_clamp != 7'd0) begin
            acc_cnt_reg <= '0;
        end else if (pop) begin
            acc_cnt_reg <= acc_cnt_reg + 7'd1;
        end
    end

    // Two-stage valid pipeline that mirrors the RAM read latency.
    always_ff @(posedge clk) begin
        if (!reset_n || abort_hit) begin
            vld1_reg <= 1'b0;
            vld2_reg <= 1'b0;
        end else begin
            vld1_reg <= issue;
            vld2_reg <= vld1_reg;
        end
    end

    // Skid FIFO bookkeeping. An abort empties the FIFO in one cycle.
    always_ff @(posedge clk) begin
        if (!reset_n || abort_hit) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            cnt_reg    <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            end
            if (pop) begin
                rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            end
            if (push && !pop) begin
                cnt_reg <= cnt_reg + 1'b1;
            end else if (!push && pop) begin
                cnt_reg <= cnt_reg - 1'b1;
            end
        end
    end

    // Skid FIFO storage. Captures RAM data as each read reaches stage 2.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= rd_dat_r;
        end
    end

endmodule
